// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared types and constants for the grey counter sequencer
package grey_pkg;

  localparam int NDIG = 12;
  localparam int DW   = 5;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_RUN      = 3'd1,
    CMD_HOLD     = 3'd2,
    CMD_STEP     = 3'd3,
    CMD_LOAD_DIG = 3'd4,
    CMD_COMMIT   = 3'd5,
    CMD_CLEAR    = 3'd6,
    CMD_SNAP     = 3'd7
  } cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Bit offset of digit sel inside a packed NDIG*DW vector.
  function automatic int dig_lsb(input logic [3:0] sel);
    return int'(sel) * DW;
  endfunction

endpackage

// File: rtl/grey_seq_ctrl_if.sv
// rtl/grey_seq_ctrl_if.sv - command, counter and scan-out signal bundle
interface grey_seq_ctrl_if;
  import grey_pkg::*;

  logic                 cmd_valid;
  logic [2:0]           cmd;
  logic                 cmd_ready;
  logic [DW-1:0]        data_in;
  logic [NDIG*DW-1:0]   digits_in;
  logic                 cnt_en;
  logic                 load;
  logic [NDIG*DW-1:0]   init;
  logic                 running;
  logic [DW-1:0]        out_digit;
  logic [3:0]           out_sel;
  logic                 out_valid;
  logic                 out_last;

  modport master (
    output cmd_valid, cmd, data_in, digits_in,
    input  cmd_ready, cnt_en, load, init, running,
    input  out_digit, out_sel, out_valid, out_last
  );

  modport slave (
    input  cmd_valid, cmd, data_in, digits_in,
    output cmd_ready, cnt_en, load, init, running,
    output out_digit, out_sel, out_valid, out_last
  );

endinterface

// File: rtl/grey_scan.sv
// rtl/grey_scan.sv - snapshots the live digits and serialises them MSD first
module grey_scan
  import grey_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                snap_i,
  input  logic [NDIG*DW-1:0]  digits_i,
  output logic                busy_o,
  output logic [DW-1:0]       out_digit_o,
  output logic [3:0]          out_sel_o,
  output logic                out_valid_o,
  output logic                out_last_o
);

  scan_state_e          state_q, state_d;
  logic [NDIG*DW-1:0]   snap_q, snap_d;
  logic [3:0]           sel_q, sel_d;
  logic [DW-1:0]        digit_q, digit_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    sel_d   = '0;
    digit_d = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_i) begin
          state_d = SCAN;
          snap_d  = digits_i;
          sel_d   = 4'(NDIG - 1);
          digit_d = digits_i[dig_lsb(sel_d) +: DW];
          valid_d = 1'b1;
        end
      end
      SCAN: begin
        // out_* fall to zero in the cycle after the ones digit.
        if (sel_q != 4'd0) begin
          sel_d   = sel_q - 4'd1;
          digit_d = snap_q[dig_lsb(sel_d) +: DW];
          valid_d = 1'b1;
          last_d  = (sel_d == 4'd0);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      sel_q   <= '0;
      digit_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign busy_o      = (state_q == SCAN);
  assign out_digit_o = digit_q;
  assign out_sel_o   = sel_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/grey_seq_ctrl.sv
// rtl/grey_seq_ctrl.sv - command decoder, prescaler, init shifter and scan-out top
module grey_seq_ctrl
  import grey_pkg::*;
#(
  parameter int unsigned DIV = 0
)
(
  input  logic        clk,
  input  logic        rst_n,
  grey_seq_ctrl_if.slave bus
);

  localparam int PW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic                 running_q, running_d;
  logic                 cnt_en_q, cnt_en_d;
  logic                 load_q, load_d;
  logic [NDIG*DW-1:0]   init_q, init_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 busy;
  logic                 acc;
  logic                 at_div;
  cmd_e                 cmd_c;

  assign cmd_c         = cmd_e'(bus.cmd);
  assign bus.cmd_ready = ~load_q & ~busy;
  assign acc           = bus.cmd_valid & bus.cmd_ready;
  assign at_div        = (presc_q == PW'(DIV));

  always_comb begin
    running_d = running_q;
    presc_d   = presc_q;
    init_d    = init_q;
    load_d    = 1'b0;
    cnt_en_d  = running_q & at_div;
    if (running_q) presc_d = at_div ? '0 : presc_q + 1'b1;
    if (acc) begin
      case (cmd_c)
        CMD_RUN:      begin running_d = 1'b1; presc_d = '0; end
        CMD_HOLD:     begin running_d = 1'b0; presc_d = '0; cnt_en_d = 1'b0; end
        CMD_STEP:     if (!running_q) cnt_en_d = 1'b1;
        CMD_LOAD_DIG: init_d = {init_q[NDIG*DW-DW-1:0], bus.data_in};
        CMD_COMMIT:   begin load_d = 1'b1; presc_d = '0; end
        CMD_CLEAR:    begin init_d = '0; load_d = 1'b1; end
        default:      ;
      endcase
    end
    // A count coinciding with a load is dropped, not deferred.
    if (load_d) cnt_en_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      load_q    <= 1'b0;
      init_q    <= '0;
      presc_q   <= '0;
    end else begin
      running_q <= running_d;
      cnt_en_q  <= cnt_en_d;
      load_q    <= load_d;
      init_q    <= init_d;
      presc_q   <= presc_d;
    end
  end

  assign bus.running = running_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.load    = load_q;
  assign bus.init    = init_q;

  grey_scan u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .snap_i      (acc && (cmd_c == CMD_SNAP)),
    .digits_i    (bus.digits_in),
    .busy_o      (busy),
    .out_digit_o (bus.out_digit),
    .out_sel_o   (bus.out_sel),
    .out_valid_o (bus.out_valid),
    .out_last_o  (bus.out_last)
  );

endmodule

// File: tb/tb_grey_seq_ctrl.sv
// tb/tb_grey_seq_ctrl.sv - self-checking bench for grey_seq_ctrl at DIV=0 and DIV=3
module tb_grey_seq_ctrl;
  import grey_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  grey_seq_ctrl_if ifc0 ();
  grey_seq_ctrl_if ifc3 ();

  grey_seq_ctrl #(.DIV(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
  grey_seq_ctrl #(.DIV(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(ifc3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       exp_run;
    logic       exp_cnt0;
    logic       exp_cnt3;
    logic       exp_load;
    logic       exp_rdy;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [4:0] dig;
  } item_t;

  // Reference model: scan-out as a queue of pending digits, prescaler as age modulo DIV+1.
  logic        m_run, m_load, m_ov, m_last;
  logic [3:0]  m_sel;
  logic [4:0]  m_dig;
  logic [59:0] m_init;
  logic        m_cnt [2];
  int          m_age [2];
  int          divs  [2];
  item_t       m_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [2:0] c, input logic [4:0] d, input logic [59:0] dig);
    ifc0.cmd_valid = v; ifc0.cmd = c; ifc0.data_in = d; ifc0.digits_in = dig;
    ifc3.cmd_valid = v; ifc3.cmd = c; ifc3.data_in = d; ifc3.digits_in = dig;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, CMD_NOP, 5'd0, 60'd0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_run = 0; m_load = 0; m_ov = 0; m_last = 0; m_sel = 0; m_dig = 0; m_init = '0;
    m_cnt = '{1'b0, 1'b0};
    m_age = '{0, 0};
    m_q.delete();
  endtask

  task automatic model_step(input logic v, input logic [2:0] c, input logic [4:0] d, input logic [59:0] dig);
    logic  acc;
    logic  was_run;
    item_t it;
    acc     = v && !m_load && !m_ov;
    was_run = m_run;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = m_run && ((m_age[k] % (divs[k] + 1)) == divs[k]);
      if (m_run) m_age[k]++;
    end
    m_load = 1'b0;
    if (acc) begin
      case (c)
        CMD_RUN:      begin m_run = 1; m_age = '{0, 0}; end
        CMD_HOLD:     begin m_run = 0; m_age = '{0, 0}; m_cnt = '{1'b0, 1'b0}; end
        CMD_STEP:     if (!was_run) m_cnt = '{1'b1, 1'b1};
        CMD_LOAD_DIG: m_init = {m_init[54:0], d};
        CMD_COMMIT:   begin m_load = 1; m_age = '{0, 0}; end
        CMD_CLEAR:    begin m_init = '0; m_load = 1; end
        CMD_SNAP: begin
          for (int s = 11; s >= 0; s--) begin
            it.sel = 4'(s);
            it.dig = dig[s*5 +: 5];
            m_q.push_back(it);
          end
        end
        default: ;
      endcase
    end
    if (m_load) m_cnt = '{1'b0, 1'b0};
    if (m_q.size() > 0) begin
      it = m_q.pop_front();
      m_ov = 1; m_sel = it.sel; m_dig = it.dig; m_last = (it.sel == 4'd0);
    end else begin
      m_ov = 0; m_sel = 0; m_dig = 0; m_last = 0;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_running"},  ifc0.running,   0);
    chk({tag, "_cnt_en"},   ifc0.cnt_en,    0);
    chk({tag, "_load"},     ifc0.load,      0);
    chk({tag, "_init"},     ifc0.init,      0);
    chk({tag, "_out_valid"},ifc0.out_valid, 0);
    chk({tag, "_out_sel"},  ifc0.out_sel,   0);
    chk({tag, "_out_digit"},ifc0.out_digit, 0);
    chk({tag, "_out_last"}, ifc0.out_last,  0);
    chk({tag, "_ready"},    ifc0.cmd_ready, 1);
    chk({tag, "_ready3"},   ifc3.cmd_ready, 1);
    chk({tag, "_valid3"},   ifc3.out_valid, 0);
    chk({tag, "_cnt_en3"},  ifc3.cnt_en,    0);
  endtask

  vec_t        tbl [11];
  logic [59:0] snap_c, alt_c, exp_init, rdig;
  logic [63:0] r64;
  logic [4:0]  exp_dig;
  logic        v;
  logic [2:0]  c;
  logic [4:0]  d;
  int          n;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    divs     = '{0, 3};
    rst_n    = 1'b1;

    tbl[0]  = '{1'b1, CMD_RUN,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, CMD_NOP,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, CMD_NOP,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, CMD_NOP,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, CMD_NOP,    1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, CMD_STEP,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, CMD_HOLD,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, CMD_STEP,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, CMD_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, CMD_COMMIT, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, CMD_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();
    chk_idle("reset");

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].v, tbl[i].c, 5'd0, 60'd0);
      tick();
      chk($sformatf("tbl%0d_running", i), ifc0.running,   tbl[i].exp_run);
      chk($sformatf("tbl%0d_cnt0", i),    ifc0.cnt_en,    tbl[i].exp_cnt0);
      chk($sformatf("tbl%0d_cnt3", i),    ifc3.cnt_en,    tbl[i].exp_cnt3);
      chk($sformatf("tbl%0d_load", i),    ifc0.load,      tbl[i].exp_load);
      chk($sformatf("tbl%0d_ready", i),   ifc0.cmd_ready, tbl[i].exp_rdy);
    end

    // Twelve digits then COMMIT while running at DIV=0.
    set_in(1'b1, CMD_RUN, 5'd0, 60'd0);
    tick();
    exp_init = '0;
    for (int i = 1; i <= 12; i++) begin
      set_in(1'b1, CMD_LOAD_DIG, 5'(i), 60'd0);
      tick();
      exp_init = {exp_init[54:0], 5'(i)};
    end
    chk("load_pre_cnt_en", ifc0.cnt_en, 1);
    chk("load_pre_strobe", ifc0.load, 0);
    set_in(1'b1, CMD_COMMIT, 5'd0, 60'd0);
    tick();
    chk("commit_load",    ifc0.load,         1);
    chk("commit_cnt_en",  ifc0.cnt_en,       0);
    chk("commit_ready",   ifc0.cmd_ready,    0);
    chk("commit_msd",     ifc0.init[59:55],  1);
    chk("commit_lsd",     ifc0.init[4:0],    12);
    chk("commit_init",    ifc0.init,         exp_init);
    set_in(1'b0, CMD_NOP, 5'd0, 60'd0);
    tick();
    chk("post_commit_load",   ifc0.load,      0);
    chk("post_commit_ready",  ifc0.cmd_ready, 1);
    chk("post_commit_cnt_en", ifc0.cnt_en,    1);
    chk("post_commit_init",   ifc0.init,      exp_init);

    // Snapshot scan while running; digits_in changes mid-scan.
    snap_c = 60'h123456789ABCDEF;
    alt_c  = 60'hFEDCBA987654321;
    set_in(1'b1, CMD_SNAP, 5'd0, snap_c);
    tick();
    for (int i = 0; i < 12; i++) begin
      exp_dig = snap_c[(11 - i)*5 +: 5];
      chk($sformatf("scan%0d_valid", i), ifc0.out_valid, 1);
      chk($sformatf("scan%0d_sel", i),   ifc0.out_sel,   11 - i);
      chk($sformatf("scan%0d_digit", i), ifc0.out_digit, exp_dig);
      chk($sformatf("scan%0d_last", i),  ifc0.out_last,  (i == 11));
      chk($sformatf("scan%0d_ready", i), ifc0.cmd_ready, 0);
      chk($sformatf("scan%0d_cnt", i),   ifc0.cnt_en,    1);
      set_in(1'b0, CMD_NOP, 5'd0, (i >= 2) ? alt_c : snap_c);
      tick();
    end
    chk("scan_end_valid", ifc0.out_valid, 0);
    chk("scan_end_last",  ifc0.out_last,  0);
    chk("scan_end_ready", ifc0.cmd_ready, 1);

    // RUN held during a scan is only consumed once out_valid drops.
    set_in(1'b1, CMD_HOLD, 5'd0, snap_c);
    tick();
    set_in(1'b1, CMD_SNAP, 5'd0, snap_c);
    tick();
    set_in(1'b1, CMD_RUN, 5'd0, snap_c);
    n = 0;
    while (ifc0.out_valid && n < 20) begin
      chk("held_run_blocked", ifc0.running, 0);
      tick();
      n++;
    end
    chk("held_scan_len",   n, 12);
    chk("held_ready_back", ifc0.cmd_ready, 1);
    chk("held_not_yet",    ifc0.running, 0);
    tick();
    chk("held_run_taken",  ifc0.running, 1);
    set_in(1'b0, CMD_NOP, 5'd0, snap_c);

    // Asynchronous reset at scan cycle 5 while running.
    set_in(1'b1, CMD_SNAP, 5'd0, snap_c);
    tick();
    set_in(1'b0, CMD_NOP, 5'd0, snap_c);
    for (int i = 0; i < 5; i++) tick();
    chk("midscan_sel", ifc0.out_sel, 6);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("abort");
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk_idle("after_abort");
    tick();
    chk("after_abort2_valid", ifc0.out_valid, 0);
    chk("after_abort2_ready", ifc0.cmd_ready, 1);

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      c   = 3'($urandom_range(0, 7));
      d   = 5'($urandom_range(0, 31));
      r64 = {$urandom(), $urandom()};
      rdig = r64[59:0];
      set_in(v, c, d, rdig);
      model_step(v, c, d, rdig);
      tick();
      chk($sformatf("rnd%0d_running", i), ifc0.running,   m_run);
      chk($sformatf("rnd%0d_cnt0", i),    ifc0.cnt_en,    m_cnt[0]);
      chk($sformatf("rnd%0d_cnt3", i),    ifc3.cnt_en,    m_cnt[1]);
      chk($sformatf("rnd%0d_load", i),    ifc0.load,      m_load);
      chk($sformatf("rnd%0d_load3", i),   ifc3.load,      m_load);
      chk($sformatf("rnd%0d_init", i),    ifc0.init,      m_init);
      chk($sformatf("rnd%0d_ready", i),   ifc0.cmd_ready, !m_load && !m_ov);
      chk($sformatf("rnd%0d_ready3", i),  ifc3.cmd_ready, !m_load && !m_ov);
      chk($sformatf("rnd%0d_valid", i),   ifc0.out_valid, m_ov);
      chk($sformatf("rnd%0d_sel", i),     ifc0.out_sel,   m_sel);
      chk($sformatf("rnd%0d_digit", i),   ifc0.out_digit, m_dig);
      chk($sformatf("rnd%0d_last", i),    ifc0.out_last,  m_last);
      chk($sformatf("rnd%0d_digit3", i),  ifc3.out_digit, m_dig);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
